fifo_burst_arbiter: RTL and testbench
=====================================

Name: fifo_burst_arbiter

Overview:
- Shares one downstream burst channel among NUM_CHN same-clock fill-level FIFOs.
- Monitors each FIFO's RAM fill and nempty flag, and grants channels round-robin.
- Drains each granted FIFO as a counted burst of up to BURST_LEN words through a valid/ready interface.
- Sits between per-source FIFOs and a shared consumer, e.g. a memory write-channel sequencer.

Parameters:
- NUM_CHN, 4: number of requesting FIFOs (2..8).
- DATA_WIDTH, 16: FIFO word width.
- FILL_WIDTH, 5: width of each FIFO's num_in_fifo output (FIFO DATA_DEPTH+1).
- BURST_LEN, 8: maximum words per burst (1..2^(FILL_WIDTH-1)).
- CNT_WIDTH, 4: burst counter width; must hold BURST_LEN.

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  clock, positive edge
- sync_rst  in  1  synchronous reset of all state, same effect as rst
- en  in  1  arbitration enable; while 0, no new grants (a burst in progress completes)
- chn_fill  in  NUM_CHN*FILL_WIDTH  per-channel RAM fill (num_in_fifo); channel i at [i*FILL_WIDTH +: FILL_WIDTH]
- chn_nempty  in  NUM_CHN  per-channel FIFO output word valid
- chn_data  in  NUM_CHN*DATA_WIDTH  per-channel FIFO data_out
- chn_flush  in  NUM_CHN  level; allows a partial burst on that channel
- chn_re  out  NUM_CHN  per-channel FIFO read enable (one-hot or zero)
- out_data  out  DATA_WIDTH  selected channel data
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word this cycle
- out_chn  out  3  granted channel index, stable for the whole burst
- out_start  out  1  one-cycle pulse at grant
- out_len  out  CNT_WIDTH  burst length, valid with out_start and held until the next grant
- out_last  out  1  high with the final word of a burst
- busy  out  1  high in GRANT, XFER, GAP

Behaviour:
- Reset (rst or sync_rst), all outputs 0:
  - state IDLE; chn_re, out_valid, out_start, out_last, busy = 0; out_chn = 0; out_len = 0.
  - Round-robin pointer = NUM_CHN-1, so channel 0 is first in priority.
- Availability and eligibility:
  - avail_i = chn_fill_i + chn_nempty_i, computed at FILL_WIDTH+1 bits with no overflow.
  - Channel i is eligible if avail_i >= BURST_LEN, or if chn_flush_i is high and avail_i != 0.
- IDLE:
  - If en is high and any channel is eligible, select the first eligible channel after the pointer (wrapping), go to GRANT.
- GRANT (1 cycle):
  - Latch out_chn = selected channel; out_len = min(avail, BURST_LEN); remaining = out_len.
  - Pulse out_start; update pointer to the selected channel; go to XFER.
- XFER:
  - out_data = chn_data[out_chn]; out_valid = chn_nempty[out_chn].
  - chn_re[out_chn] = out_valid & out_ready. Each accepted word decrements remaining.
  - out_last = out_valid & (remaining == 1).
  - When the last word is accepted, go to GAP.
  - If out_valid drops mid-burst (FIFO output refill), stall without error; the burst length is not reduced.
- GAP:
  - 2 cycles with no reads, so registered FIFO fill/nempty reflect the reads; then IDLE.
- Timing:
  - Grant-to-first-word latency: eligible in IDLE at cycle N -> out_start at N+1 -> first out_valid at N+2.
  - Back-to-back bursts: at least 3 idle cycles between the last word and the next out_start.
- Boundary conditions:
  - Counter wrap: remaining never wraps below 0; XFER exits exactly at 0.
  - Inputs changing mid-burst: flush deassertion or fill changes during XFER do not affect the current burst.
  - en low: blocks GRANT only; it does not stop XFER.
  - sync_rst mid-burst: returns to IDLE the next cycle with chn_re = 0. Words already read are lost, which is acceptable.
  - Simultaneous eligibility: strict round-robin; a channel eligible continuously is served within NUM_CHN grants.

Optional Feature:
- Macro: FIFO_BURST_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_bursts [15:0]: count of completed bursts, wrapping at 16 bits.
  - stat_stall [15:0]: count of XFER cycles with out_valid=0, saturating at 0xFFFF.
  - Both cleared by rst/sync_rst.
- When undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Channel 2 fill=7, nempty=1, others empty, en=1 -> out_start with out_chn=2, out_len=8; 8 words with chn_re[2] pulses; out_last on the 8th word; then GAP, then IDLE.
- All 4 channels with avail>=8 held -> grant order 0,1,2,3,0; each burst 8 words.
- Channel 1 avail=3, flush=1 -> out_len=3, 3 words, out_last on the 3rd. Same with flush=0 -> no grant.
- out_ready toggling 1,0,1,0 during a burst -> chn_re only on accepted cycles; 8 words total; out_data matches the FIFO word order.
- sync_rst asserted after word 4 of 8 -> next cycle IDLE, chn_re=0, busy=0; the pointer reset makes channel 0 next first.
- en=0 with channel 0 eligible -> no out_start. en dropped mid-burst -> the burst completes, with no new grant afterwards.

Source files
------------

// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: round-robin burst drain of NUM_CHN fill-level FIFOs
// onto one valid/ready channel. Optional stats: FIFO_BURST_ARB_STATS_EN.
// Ports: rst (async, high), clk, sync_rst; en gates new grants only;
//   chn_fill/chn_nempty/chn_data/chn_flush: per-FIFO status and data;
//   chn_re: per-FIFO read enable; out_data/out_valid/out_ready/out_last:
//   word stream; out_chn/out_start/out_len: burst header; busy: not IDLE;
//   stat_bursts/stat_stall: counters, present only with the stats macro.
module fifo_burst_arbiter #(
    parameter int NUM_CHN    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int FILL_WIDTH = 5,
    parameter int BURST_LEN  = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                          rst,
    input  logic                          clk,
    input  logic                          sync_rst,
    input  logic                          en,
    input  logic [NUM_CHN*FILL_WIDTH-1:0] chn_fill,
    input  logic [NUM_CHN-1:0]            chn_nempty,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] chn_data,
    input  logic [NUM_CHN-1:0]            chn_flush,
    output logic [NUM_CHN-1:0]            chn_re,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2:0]                    out_chn,
    output logic                          out_start,
    output logic [CNT_WIDTH-1:0]          out_len,
    output logic                          out_last,
    output logic                          busy
`ifdef FIFO_BURST_ARB_STATS_EN
    ,
    output logic [15:0]                   stat_bursts,
    output logic [15:0]                   stat_stall
`endif
);
    localparam int IW = $clog2(NUM_CHN);
    localparam int AW = FILL_WIDTH + 1;
    localparam logic [AW-1:0] BL_A = AW'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] BL_C = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] ONE_C = CNT_WIDTH'(1);
    localparam logic [IW:0] NCH = (IW+1)'(NUM_CHN);
    localparam logic [IW-1:0] PTR_RST = IW'(NUM_CHN - 1);

    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;

    state_t               state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        cur;
    logic [IW-1:0]        sel;
    logic [CNT_WIDTH-1:0] remaining;
    logic [CNT_WIDTH-1:0] sel_len;
    logic                 gap_cnt;
    logic                 any_elig;
    logic                 fire;
    logic [NUM_CHN-1:0]   elig;
    logic [AW-1:0]        avail  [NUM_CHN];
    logic [DATA_WIDTH-1:0] data_a [NUM_CHN];

    // avail counts the RAM words plus the word sitting on the FIFO output
    for (genvar i = 0; i < NUM_CHN; i++) begin : g_chn
        assign avail[i] = {1'b0, chn_fill[i*FILL_WIDTH +: FILL_WIDTH]}
                        + AW'(chn_nempty[i]);
        assign data_a[i] = chn_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign elig[i] = (avail[i] >= BL_A)
                       || (chn_flush[i] && (avail[i] != '0));
    end

    // first eligible channel strictly after ptr, wrapping
    always_comb begin
        logic [IW:0] idx;
        any_elig = 1'b0;
        sel = '0;
        idx = '0;
        for (int k = 1; k <= NUM_CHN; k++) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= NCH) idx = idx - NCH;
            if (!any_elig && elig[idx[IW-1:0]]) begin
                any_elig = 1'b1;
                sel = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        if (avail[sel] >= BL_A) sel_len = BL_C;
        else                    sel_len = CNT_WIDTH'(avail[sel]);
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == XFER) && chn_nempty[cur];
    assign out_data  = (state == XFER) ? data_a[cur] : '0;
    assign fire      = out_valid && out_ready;
    assign chn_re    = fire ? (NUM_CHN'(1) << cur) : '0;
    assign out_last  = out_valid && (remaining == ONE_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            cur       <= '0;
            remaining <= '0;
            gap_cnt   <= 1'b0;
            out_chn   <= '0;
            out_len   <= '0;
            out_start <= 1'b0;
        end else if (sync_rst) begin
            state     <= IDLE;
            ptr       <= PTR_RST;
            cur       <= '0;
            remaining <= '0;
            gap_cnt   <= 1'b0;
            out_chn   <= '0;
            out_len   <= '0;
            out_start <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en && any_elig) begin
                        cur       <= sel;
                        ptr       <= sel;
                        out_chn   <= 3'(sel);
                        out_len   <= sel_len;
                        remaining <= sel_len;
                        out_start <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    out_start <= 1'b0;
                    state     <= XFER;
                end
                XFER: begin
                    if (fire) begin
                        remaining <= remaining - ONE_C;
                        if (remaining <= ONE_C) begin
                            gap_cnt <= 1'b0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    // two quiet cycles let the FIFO status registers settle
                    gap_cnt <= 1'b1;
                    if (gap_cnt) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_BURST_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_bursts <= '0;
            stat_stall  <= '0;
        end else if (sync_rst) begin
            stat_bursts <= '0;
            stat_stall  <= '0;
        end else begin
            if (fire && out_last)
                stat_bursts <= stat_bursts + 16'd1;
            if ((state == XFER) && !out_valid && (stat_stall != 16'hFFFF))
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// tb_fifo_burst_arbiter: directed scoreboard bench for fifo_burst_arbiter
// with a behavioural FIFO model per channel.
module tb_fifo_burst_arbiter;
    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int FW  = 5;
    localparam int CW  = 4;

    logic              rst;
    logic              clk;
    logic              sync_rst;
    logic              en;
    logic [NCH*FW-1:0] chn_fill;
    logic [NCH-1:0]    chn_nempty;
    logic [NCH*DW-1:0] chn_data;
    logic [NCH-1:0]    chn_flush;
    logic [NCH-1:0]    chn_re;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_chn;
    logic              out_start;
    logic [CW-1:0]     out_len;
    logic              out_last;
    logic              busy;

    fifo_burst_arbiter #(
        .NUM_CHN(NCH), .DATA_WIDTH(DW), .FILL_WIDTH(FW),
        .BURST_LEN(8), .CNT_WIDTH(CW)
    ) dut (
        .rst(rst), .clk(clk), .sync_rst(sync_rst), .en(en),
        .chn_fill(chn_fill), .chn_nempty(chn_nempty),
        .chn_data(chn_data), .chn_flush(chn_flush), .chn_re(chn_re),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_chn(out_chn),
        .out_start(out_start), .out_len(out_len),
        .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  chn;
        logic [15:0] data;
        logic        last;
    } wexp_t;

    typedef struct packed {
        logic [2:0] chn;
        logic [3:0] len;
    } sexp_t;

    wexp_t exp_w[$];
    sexp_t exp_s[$];

    logic [15:0]    mem [NCH][64];
    int             rd [NCH];
    int             wr [NCH];
    int             checks;
    int             failures;
    int             cyc;
    int             last_cyc;
    logic           rdy_tog;
    logic [NCH-1:0] re_pend;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wd(input int ch, input int s);
        return 16'(ch * 256 + s);
    endfunction

    function automatic int cnt(input int ch);
        return wr[ch] - rd[ch];
    endfunction

    task automatic refresh();
        for (int i = 0; i < NCH; i++) begin
            int n;
            n = wr[i] - rd[i];
            chn_nempty[i] = (n > 0);
            chn_fill[i*FW +: FW] = (n > 0) ? FW'(n - 1) : '0;
            chn_data[i*DW +: DW] = (n > 0) ? mem[i][6'(rd[i])] : '0;
        end
    endtask

    task automatic load(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][6'(wr[ch])] = wd(ch, wr[ch]);
            wr[ch]++;
        end
        refresh();
    endtask

    task automatic expect_burst(input int ch, input int first,
                                input int len, input int nw);
        sexp_t s;
        wexp_t w;
        s.chn = 3'(ch);
        s.len = 4'(len);
        exp_s.push_back(s);
        for (int k = 0; k < nw; k++) begin
            w.chn  = 3'(ch);
            w.data = wd(ch, first + k);
            w.last = (k == len - 1);
            exp_w.push_back(w);
        end
    endtask

    task automatic monitor();
        sexp_t s;
        wexp_t w;
        logic [NCH-1:0] exp_re;
        exp_re = '0;
        if (out_start) begin
            chk("start_pending", 32'(exp_s.size() > 0), 32'd1);
            if (exp_s.size() > 0) begin
                s = exp_s.pop_front();
                chk("start_chn", 32'(out_chn), 32'(s.chn));
                chk("start_len", 32'(out_len), 32'(s.len));
                if (last_cyc >= 0)
                    chk("burst_spacing", 32'(cyc - last_cyc >= 4), 32'd1);
            end
        end
        if (out_valid && out_ready) begin
            chk("word_pending", 32'(exp_w.size() > 0), 32'd1);
            if (exp_w.size() > 0) begin
                w = exp_w.pop_front();
                exp_re = NCH'(1) << w.chn;
                chk("word_data", 32'(out_data), 32'(w.data));
                chk("word_last", 32'(out_last), 32'(w.last));
                if (w.last) last_cyc = cyc;
            end
        end
        chk("chn_re", 32'(chn_re), 32'(exp_re));
        re_pend = chn_re;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < NCH; i++)
            if (re_pend[i] && (wr[i] > rd[i])) rd[i]++;
        out_ready = rdy_tog ? ~out_ready : 1'b1;
        refresh();
        #1;
        monitor();
    endtask

    task automatic run_drain(input int budget, input string tag);
        int n;
        n = 0;
        while ((exp_w.size() > 0 || exp_s.size() > 0) && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(exp_w.size() + exp_s.size()), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        last_cyc = -1;
        rdy_tog = 1'b0;
        re_pend = '0;
        rst = 1'b1;
        sync_rst = 1'b0;
        en = 1'b0;
        out_ready = 1'b1;
        chn_flush = '0;
        for (int i = 0; i < NCH; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        refresh();
        repeat (2) @(posedge clk);
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_re", 32'(chn_re), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_start", 32'(out_start), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_chn", 32'(out_chn), 32'd0);
        chk("rst_len", 32'(out_len), 32'd0);
        rst = 1'b0;
        en = 1'b1;
        step();
        step();

        // round robin over all channels
        load(0, 16);
        load(1, 8);
        load(2, 8);
        load(3, 8);
        expect_burst(0, 0, 8, 8);
        expect_burst(1, 0, 8, 8);
        expect_burst(2, 0, 8, 8);
        expect_burst(3, 0, 8, 8);
        expect_burst(0, 8, 8, 8);
        run_drain(300, "rr_drain");
        repeat (3) step();
        chk("rr_idle", 32'(busy), 32'd0);
        chk("rr_empty", 32'(cnt(0) + cnt(1) + cnt(2) + cnt(3)), 32'd0);

        // single channel, latency and gap
        load(2, 8);
        expect_burst(2, 8, 8, 8);
        step();
        chk("lat_start", 32'(out_start), 32'd1);
        step();
        chk("lat_valid", 32'(out_valid), 32'd1);
        run_drain(50, "t1_drain");
        step();
        chk("gap1_busy", 32'(busy), 32'd1);
        chk("gap1_valid", 32'(out_valid), 32'd0);
        step();
        chk("gap2_busy", 32'(busy), 32'd1);
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("len_held", 32'(out_len), 32'd8);
        chk("t1_empty", 32'(cnt(2)), 32'd0);

        // partial burst needs flush
        load(1, 3);
        repeat (10) step();
        chk("noflush_idle", 32'(busy), 32'd0);
        chk("noflush_cnt", 32'(cnt(1)), 32'd3);
        chn_flush[1] = 1'b1;
        expect_burst(1, 8, 3, 3);
        step();
        chn_flush[1] = 1'b0;
        run_drain(50, "flush_drain");
        repeat (4) step();
        chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_cnt", 32'(cnt(1)), 32'd0);

        // consumer back-pressure
        load(3, 8);
        expect_burst(3, 8, 8, 8);
        rdy_tog = 1'b1;
        run_drain(80, "tog_drain");
        rdy_tog = 1'b0;
        repeat (4) step();
        chk("tog_idle", 32'(busy), 32'd0);
        chk("tog_cnt", 32'(cnt(3)), 32'd0);

        // sync_rst mid-burst
        load(0, 8);
        expect_burst(0, 16, 8, 4);
        run_drain(50, "srst_pre");
        sync_rst = 1'b1;
        step();
        chk("srst_busy", 32'(busy), 32'd0);
        chk("srst_re", 32'(chn_re), 32'd0);
        chk("srst_valid", 32'(out_valid), 32'd0);
        chk("srst_start", 32'(out_start), 32'd0);
        chk("srst_len", 32'(out_len), 32'd0);
        chk("srst_chn", 32'(out_chn), 32'd0);
        sync_rst = 1'b0;
        chk("srst_cnt", 32'(cnt(0)), 32'd4);
        load(3, 8);
        load(0, 4);
        expect_burst(0, 20, 8, 8);
        expect_burst(3, 16, 8, 8);
        run_drain(100, "srst_rr");
        repeat (4) step();

        // enable gating
        en = 1'b0;
        load(0, 8);
        repeat (10) step();
        chk("en0_idle", 32'(busy), 32'd0);
        en = 1'b1;
        expect_burst(0, 28, 8, 8);
        step();
        step();
        en = 1'b0;
        load(1, 8);
        run_drain(50, "en_mid");
        repeat (10) step();
        chk("en0_after", 32'(busy), 32'd0);
        chk("en0_cnt", 32'(cnt(1)), 32'd8);
        en = 1'b1;
        expect_burst(1, 11, 8, 8);
        run_drain(50, "en_resume");
        repeat (4) step();
        chk("end_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
